// File: rtl/pattern_seq_ctrl.sv
// Frame sequencer: plays a programmable pattern table frame by frame, generating f_sync/sync timing.
// Latency: start sampled at N -> busy/f_sync/sync and entry 0 config at N+1; done one cycle after last pixel.
// No backpressure: free-running timing once started; build option PSEQ_LOOP_EN loops the table until stop.
module pattern_seq_ctrl #(
  parameter int LINES_PER_FRAME = 24,
  parameter int LINE_PERIOD     = 1350,
  parameter int NUM_ENTRIES     = 8,
  localparam int IDX_W = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_addr,
  input  logic [2:0]       wr_mode,
  input  logic [11:0]      wr_const,
  input  logic [1:0]       wr_dx,
  input  logic [1:0]       wr_dy,
  input  logic [4:0]       seq_len,
  input  logic             start,
  input  logic             stop,
  output logic             f_sync,
  output logic             sync,
  output logic [2:0]       Mode,
  output logic [11:0]      constVal,
  output logic [1:0]       X,
  output logic [1:0]       Y,
  output logic [IDX_W-1:0] entry_idx,
  output logic             busy,
  output logic             done
);

  localparam int PIX_W = (LINE_PERIOD > 1) ? $clog2(LINE_PERIOD) : 1;
  localparam int LN_W  = (LINES_PER_FRAME > 1) ? $clog2(LINES_PER_FRAME) : 1;
  localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(LINE_PERIOD - 1);
  localparam logic [LN_W-1:0]  LN_LAST  = LN_W'(LINES_PER_FRAME - 1);
  localparam logic [IDX_W-1:0] IDX_MAX  = IDX_W'(NUM_ENTRIES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  typedef struct packed {
    logic [2:0]  mode;
    logic [11:0] cval;
    logic [1:0]  dx;
    logic [1:0]  dy;
  } entry_t;

  entry_t tbl [NUM_ENTRIES];

  state_t           state_q, state_d;
  logic [PIX_W-1:0] pix_q, pix_d;
  logic [LN_W-1:0]  line_q, line_d;
  logic [IDX_W-1:0] last_q, last_d;
  logic             stop_q, stop_d;

  logic             f_sync_d, sync_d, busy_d, done_d;
  logic [2:0]       mode_d;
  logic [11:0]      cval_d;
  logic [1:0]       x_d, y_d;
  logic [IDX_W-1:0] idx_d;

  logic             load_en;
  logic [IDX_W-1:0] load_idx;
  logic             finish;

  // Pattern table: writable only while idle so a running sequence sees a frozen table.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_ENTRIES; i++) tbl[i] <= '0;
    end else if (wr_en && state_q == IDLE) begin
      tbl[wr_addr] <= '{mode: wr_mode, cval: wr_const, dx: wr_dx, dy: wr_dy};
    end
  end

  // Next-state, counters and next output values; every output is registered below.
  always_comb begin
    state_d  = state_q;
    pix_d    = pix_q;
    line_d   = line_q;
    last_d   = last_q;
    stop_d   = stop_q;
    f_sync_d = 1'b0;
    sync_d   = 1'b0;
    done_d   = 1'b0;
    busy_d   = busy;
    mode_d   = Mode;
    cval_d   = constVal;
    x_d      = X;
    y_d      = Y;
    idx_d    = entry_idx;
    load_en  = 1'b0;
    load_idx = '0;
    finish   = 1'b0;

    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        // A simultaneous stop cancels the start request.
        if (start && !stop && seq_len != 5'd0) begin
          state_d  = RUN;
          pix_d    = '0;
          line_d   = '0;
          stop_d   = 1'b0;
          busy_d   = 1'b1;
          sync_d   = 1'b1;
          load_en  = 1'b1;
          load_idx = '0;
          if (seq_len > 5'(NUM_ENTRIES)) last_d = IDX_MAX;
          else                           last_d = IDX_W'(seq_len - 5'd1);
        end
      end

      RUN: begin
        if (stop) stop_d = 1'b1;
        if (pix_q == PIX_LAST) begin
          pix_d  = '0;
          sync_d = 1'b1;
          if (line_q == LN_LAST) begin
            line_d = '0;
            // Frame boundary: end on request, otherwise advance (or wrap) the entry.
            if (stop_q || stop) begin
              finish = 1'b1;
            end else if (entry_idx == last_q) begin
`ifdef PSEQ_LOOP_EN
              load_en  = 1'b1;
              load_idx = '0;
`else
              finish   = 1'b1;
`endif
            end else begin
              load_en  = 1'b1;
              load_idx = entry_idx + 1'b1;
            end
          end else begin
            line_d = line_q + 1'b1;
          end
        end else begin
          pix_d = pix_q + 1'b1;
        end
      end

      DONE: begin
        state_d = IDLE;
        stop_d  = 1'b0;
      end

      default: state_d = IDLE;
    endcase

    if (finish) begin
      state_d = DONE;
      done_d  = 1'b1;
      busy_d  = 1'b0;
      mode_d  = 3'd0;
      sync_d  = 1'b0;
      stop_d  = 1'b0;
      pix_d   = '0;
      line_d  = '0;
    end

    // Configuration only changes together with the f_sync that opens a frame.
    if (load_en) begin
      f_sync_d = 1'b1;
      idx_d    = load_idx;
      mode_d   = tbl[load_idx].mode;
      cval_d   = tbl[load_idx].cval;
      x_d      = tbl[load_idx].dx;
      y_d      = tbl[load_idx].dy;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      pix_q     <= '0;
      line_q    <= '0;
      last_q    <= '0;
      stop_q    <= 1'b0;
      f_sync    <= 1'b0;
      sync      <= 1'b0;
      Mode      <= '0;
      constVal  <= '0;
      X         <= '0;
      Y         <= '0;
      entry_idx <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_q   <= state_d;
      pix_q     <= pix_d;
      line_q    <= line_d;
      last_q    <= last_d;
      stop_q    <= stop_d;
      f_sync    <= f_sync_d;
      sync      <= sync_d;
      Mode      <= mode_d;
      constVal  <= cval_d;
      X         <= x_d;
      Y         <= y_d;
      entry_idx <= idx_d;
      busy      <= busy_d;
      done      <= done_d;
    end
  end

endmodule

// File: doc/pattern_seq_ctrl.md
# pattern_seq_ctrl

Frame sequencer that drives the pattern generator. Holds a small programmable table of test patterns (mode, constant, ramp deltas) and plays them back frame by frame, generating the `f_sync`/`sync` timing and presenting a frame-stable configuration. It sits between the register/host interface and the pattern generator, replacing hand-driven sync and mode stimulus.

## Interface
- `LINES_PER_FRAME`, 24, lines per frame (≥1)
- `LINE_PERIOD`, 1350, clock cycles per line including the sync cycle (≥2)
- `NUM_ENTRIES`, 8, pattern table depth (power of 2, ≤16)

- `clk`  in  1  master clock (16 ns)
- `rst`  in  1  reset, asynchronous, active-high
- `wr_en`  in  1  table write strobe
- `wr_addr`  in  log2(NUM_ENTRIES)  table entry index
- `wr_mode`  in  3  pattern mode for entry
- `wr_const`  in  12  constant value for entry
- `wr_dx`, `wr_dy`  in  2 each  ramp deltas for entry
- `seq_len`  in  5  number of table entries to play (1..NUM_ENTRIES)
- `start`  in  1  one-cycle request to begin a sequence
- `stop`  in  1  one-cycle request to end after current frame
- `f_sync`  out  1  first-line sync pulse to generator
- `sync`  out  1  line sync pulse to generator
- `Mode`  out  3  current pattern mode
- `constVal`  out  12  current constant value
- `X`, `Y`  out  2 each  current ramp deltas
- `entry_idx`  out  log2(NUM_ENTRIES)  entry being played
- `busy`  out  1  sequence in progress
- `done`  out  1  one-cycle pulse at sequence completion

## Operation
- Reset: all outputs 0; table entries 0; line/pixel counters 0; state IDLE; pending stop cleared.
- States: IDLE, RUN, DONE.
- IDLE: `wr_en` writes entry `wr_addr`. `start` with valid `seq_len` → RUN, entry 0 loaded. `seq_len`=0 → start ignored; `seq_len`>NUM_ENTRIES clamped to NUM_ENTRIES. `stop` together with `start` in IDLE: stop wins, stay IDLE.
- RUN: pixel counter 0..LINE_PERIOD-1; line counter 0..LINES_PER_FRAME-1. `sync`=1 when pixel counter = 0. `f_sync`=1 when pixel and line counters both 0. Writes ignored (table frozen).
- Frame end (last pixel of last line): if stop pending or last entry played → DONE; else `entry_idx`+1 and next frame begins with new configuration.
- `stop` in RUN: latched; current frame completes fully, then DONE. `start` in RUN ignored.
- DONE: `done`=1 for one cycle, `busy`=0, `Mode` driven 0, → IDLE. Pending stop cleared.
- Mode values passed unchanged (0 included); no validation.

## Timing
- `start` sampled at cycle N → `busy`, `f_sync`, `sync` high and entry 0 config on outputs at N+1.
- `sync` period exactly LINE_PERIOD cycles, width 1 cycle; `f_sync` every LINES_PER_FRAME×LINE_PERIOD cycles.
- `Mode`/`constVal`/`X`/`Y`/`entry_idx` change only in the cycle `f_sync` rises (registered, same edge); stable for the whole frame.
- Last frame's final pixel at cycle M → `done`=1 and `busy`=0 at M+1; `start` accepted again from M+2.
- Back-to-back frames: no gap cycles between last pixel of one frame and `f_sync` of next.
- `rst` mid-sequence: outputs to reset values immediately (asynchronous); table cleared.
- All outputs registered; no combinational input-to-output paths.

## Configuration
- `PSEQ_LOOP_EN` defined: after the last entry, `entry_idx` wraps to 0 and playback continues indefinitely; only `stop` (or reset) ends the sequence, `done` pulses after the stopped frame.
- Not defined: single pass over `seq_len` entries, then DONE automatically; `stop` still ends early at frame boundary.

## Test plan
- Bench parameters LINES_PER_FRAME=4, LINE_PERIOD=10.
- Write entries 0..2 = modes 1,2,7 (const 12, dx=dy=2), `seq_len`=3, `start` → three frames of 40 cycles, `f_sync` at offsets 1/41/81, `Mode` 1→2→7, `done` at cycle 121, `busy` low after.
- `sync` check: within one frame `sync` at offsets 0,10,20,30; `f_sync` only at offset 0.
- `stop` asserted mid-frame 0 of 3-entry sequence → frame 0 completes (40 cycles), `done` pulses, entries 1–2 never played.
- `wr_en` to entry 0 while busy → table unchanged on next sequence; `start` while busy and `seq_len`=0 start → ignored.
- `rst` asserted at frame 1 line 2 → all outputs 0 same cycle; restart after release begins at entry 0.
- With `PSEQ_LOOP_EN`, `seq_len`=2 → `entry_idx` sequence 0,1,0,1 until `stop`; no `done` before stop.
